// File: rtl/axil_rd_router_pkg.sv
// Shared types and constants for the AXI-Lite read-address router.
package axil_rd_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/axil_addr_match.sv
// Address window decoder: one-hot slave select, lowest matching index wins.
module axil_addr_match
  import axil_rd_router_pkg::*;
#(
  parameter int unsigned NUMBER_SLAVE   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] OFFSET [NUMBER_SLAVE] = '{default: '0},
  parameter logic [AXI_ADDR_WIDTH-1:0] RANGE  [NUMBER_SLAVE] = '{default: AXI_ADDR_WIDTH'(1)}
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [NUMBER_SLAVE-1:0]   sel,
  output logic                      illegal
);

  // One extra bit so a window ending exactly at the top of the space does not wrap.
  localparam int unsigned EXT_W = AXI_ADDR_WIDTH + 1;

  logic [EXT_W-1:0]        addr_ext;
  logic [NUMBER_SLAVE-1:0] hit;

  assign addr_ext = EXT_W'(addr);

  for (genvar g = 0; g < int'(NUMBER_SLAVE); g++) begin : g_win
    localparam logic [EXT_W-1:0] LO = EXT_W'(OFFSET[g]);
    localparam logic [EXT_W-1:0] HI = LO + EXT_W'(RANGE[g]);
    assign hit[g] = (RANGE[g] != '0) && (addr_ext >= LO) && (addr_ext < HI);
  end

  // Scan from the top so the lowest hit is the last one written.
  always_comb begin
    sel = '0;
    for (int i = int'(NUMBER_SLAVE) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  assign illegal = ~|hit;

endmodule

// File: rtl/axil_rd_addr_router.sv
// Single-outstanding AXI-Lite read router: decode AR, forward to one slave,
// return its R beat, or answer unmapped addresses locally with DECERR.
module axil_rd_addr_router
  import axil_rd_router_pkg::*;
#(
  parameter int unsigned NUMBER_SLAVE   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] = '{default: '0},
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  [NUMBER_SLAVE] = '{default: AXI_ADDR_WIDTH'(1)},
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [AXI_ADDR_WIDTH-1:0]              s_axil_araddr,
  input  logic [2:0]                             s_axil_arprot,
  input  logic                                   s_axil_arvalid,
  output logic                                   s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]              s_axil_rdata,
  output logic [1:0]                             s_axil_rresp,
  output logic                                   s_axil_rvalid,
  input  logic                                   s_axil_rready,
  output logic [AXI_ADDR_WIDTH-1:0]              m_axil_araddr,
  output logic [2:0]                             m_axil_arprot,
  output logic [NUMBER_SLAVE-1:0]                m_axil_arvalid,
  input  logic [NUMBER_SLAVE-1:0]                m_axil_arready,
  input  logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [NUMBER_SLAVE*2-1:0]              m_axil_rresp,
  input  logic [NUMBER_SLAVE-1:0]                m_axil_rvalid,
  output logic [NUMBER_SLAVE-1:0]                m_axil_rready,
  output logic [ERR_CNT_W-1:0]                   err_count
);

  localparam int unsigned DW = AXI_DATA_WIDTH;
  localparam logic [DW-1:0] ERR_DATA_W = DW'(ERR_DATA);

  state_t state, state_d;

  logic [NUMBER_SLAVE-1:0]   match_sel;
  logic                      match_illegal;
  logic [NUMBER_SLAVE-1:0]   sel_q, sel_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [2:0]                prot_q;
  logic                      arready_q, arready_d;
  logic [NUMBER_SLAVE-1:0]   arvalid_q, arvalid_d;
  logic                      err_rvalid_q, err_rvalid_d;
  logic [DW-1:0]             err_rdata_q, err_rdata_d;
  logic [1:0]                err_rresp_q, err_rresp_d;
  logic [ERR_CNT_W-1:0]      err_cnt_q;
  logic [DW-1:0]             slv_rdata;
  logic [1:0]                slv_rresp;
  logic                      slv_rvalid;
  logic                      ar_hs;
  logic                      r_hs;

  axil_addr_match #(
    .NUMBER_SLAVE   (NUMBER_SLAVE),
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .OFFSET         (AXI_ADDR_OFFSET),
    .RANGE          (AXI_ADDR_RANGE)
  ) u_match (
    .addr    (s_axil_araddr),
    .sel     (match_sel),
    .illegal (match_illegal)
  );

  assign ar_hs = s_axil_arvalid && arready_q;
  assign r_hs  = s_axil_rvalid && s_axil_rready;

  // State register
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (ar_hs) state_d = match_illegal ? ERR : ADDR;
      ADDR: if (|(m_axil_arready & sel_q)) state_d = RESP;
      RESP: if (r_hs) state_d = IDLE;
      ERR:  if (s_axil_rready) state_d = IDLE;
    endcase
  end

  // Output logic: next values of registered outputs plus the combinational R path
  always_comb begin
    sel_d        = ar_hs ? match_sel : sel_q;
    arready_d    = (state_d == IDLE);
    arvalid_d    = (state_d == ADDR) ? sel_d : '0;
    err_rvalid_d = (state_d == ERR);
    err_rdata_d  = (state_d == ERR) ? ERR_DATA_W : '0;
    err_rresp_d  = (state_d == ERR) ? RESP_DECERR : RESP_OKAY;

    slv_rdata  = '0;
    slv_rresp  = RESP_OKAY;
    slv_rvalid = 1'b0;
    for (int i = 0; i < int'(NUMBER_SLAVE); i++) begin
      if (sel_q[i]) begin
        slv_rdata  = m_axil_rdata[i*DW +: DW];
        slv_rresp  = m_axil_rresp[i*2 +: 2];
        slv_rvalid = m_axil_rvalid[i];
      end
    end

    if (state == RESP) begin
      s_axil_rvalid = slv_rvalid;
      s_axil_rdata  = slv_rdata;
      s_axil_rresp  = slv_rresp;
      m_axil_rready = sel_q & {NUMBER_SLAVE{s_axil_rready}};
    end else begin
      s_axil_rvalid = err_rvalid_q;
      s_axil_rdata  = err_rdata_q;
      s_axil_rresp  = err_rresp_q;
      m_axil_rready = '0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      sel_q        <= '0;
      addr_q       <= '0;
      prot_q       <= '0;
      arready_q    <= 1'b0;
      arvalid_q    <= '0;
      err_rvalid_q <= 1'b0;
      err_rdata_q  <= '0;
      err_rresp_q  <= RESP_OKAY;
      err_cnt_q    <= '0;
    end else begin
      sel_q        <= sel_d;
      arready_q    <= arready_d;
      arvalid_q    <= arvalid_d;
      err_rvalid_q <= err_rvalid_d;
      err_rdata_q  <= err_rdata_d;
      err_rresp_q  <= err_rresp_d;
      if (ar_hs) begin
        addr_q <= s_axil_araddr;
        prot_q <= s_axil_arprot;
      end
      if ((state == ERR) && s_axil_rready && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign s_axil_arready = arready_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = prot_q;
  assign err_count      = err_cnt_q;

  a_arvalid_onehot: assert property (@(posedge aclk) disable iff (areset)
    $onehot0(m_axil_arvalid));
  a_rready_onehot: assert property (@(posedge aclk) disable iff (areset)
    $onehot0(m_axil_rready));
  a_rvalid_hold: assert property (@(posedge aclk)
    (!areset && s_axil_rvalid && !s_axil_rready) |=> (s_axil_rvalid || areset));

endmodule
